// File: rtl/pool_max_ctrl_pkg.sv
// Shared max-pooling definitions: controller state encoding and the
// float-style field positions used by the comparator.
package pool_max_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Field positions are functions because the element width is a parameter.
    function automatic int sign_bit(input int dw);
        return dw - 1;
    endfunction

    function automatic int exp_msb(input int dw);
        return dw - 2;
    endfunction

    function automatic int exp_lsb(input int dw);
        return dw - 9;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_max_ctrl_alu_max.sv
// Sign-magnitude maximum of a new element and the running max.
// Combinational; ties select the new element.
module alu_max
    import pool_max_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] in,
    input  logic [DATA_WIDTH-1:0] r,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int SB = sign_bit(DATA_WIDTH);
    localparam int EM = exp_msb(DATA_WIDTH);

    // Same-sign operands compare on raw magnitude bits, so for two negatives
    // the larger magnitude wins.
    always_comb begin
        result = in;
        if (in[SB] != r[SB]) begin
            result = in[SB] ? r : in;
        end else if (in[EM:0] < r[EM:0]) begin
            result = r;
        end
    end

endmodule

// File: rtl/pool_max_ctrl.sv
// Max-pooling sequencer: folds WIN_LEN streamed elements per window into a
// running max and presents one held result per window, cfg_num_win per frame.
module pool_max_ctrl
    import pool_max_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int WIN_LEN    = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      cfg_num_win,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int             EW        = cnt_width(WIN_LEN);
    localparam logic [EW-1:0]  ELEM_LAST = EW'(WIN_LEN - 1);

    state_t                  state;
    logic [EW-1:0]           elem_cnt;
    logic [CNT_W-1:0]        win_left;
    logic [DATA_WIDTH-1:0]   run_max;
    logic [DATA_WIDTH-1:0]   alu_out;

    alu_max #(.DATA_WIDTH(DATA_WIDTH)) u_alu_max (
        .in     (in_data),
        .r      (run_max),
        .result (alu_out)
    );

    // Every output is a decode of state/registers, never of in_* or out_ready.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign out_last  = (state == HOLD) && (win_left == CNT_W'(1));
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign out_data  = run_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            elem_cnt <= '0;
            win_left <= '0;
            run_max  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        elem_cnt <= '0;
                        win_left <= cfg_num_win;
                        state    <= (cfg_num_win != '0) ? ACCUM : DONE;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        // First element of a window seeds the max directly.
                        run_max <= (elem_cnt == '0) ? in_data : alu_out;
                        if (elem_cnt == ELEM_LAST) begin
                            elem_cnt <= '0;
                            state    <= HOLD;
                        end else begin
                            elem_cnt <= elem_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        win_left <= win_left - 1'b1;
                        state    <= (win_left == CNT_W'(1)) ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_max_ctrl.sv
// Directed bench for pool_max_ctrl: a WIN_LEN=4 instance for most scenarios
// and a WIN_LEN=1 instance for the pass-through case.
module tb_pool_max_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_num_win;
    logic        busy, done;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;

    logic        w_start;
    logic [15:0] w_cfg;
    logic        w_busy, w_done;
    logic        w_in_valid;
    logic [15:0] w_in_data;
    logic        w_in_ready;
    logic        w_out_valid;
    logic [15:0] w_out_data;
    logic        w_out_last;
    logic        w_out_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pool_max_ctrl #(.DATA_WIDTH(16), .WIN_LEN(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_win(cfg_num_win),
        .busy(busy), .done(done), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready)
    );

    pool_max_ctrl #(.DATA_WIDTH(16), .WIN_LEN(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .start(w_start), .cfg_num_win(w_cfg),
        .busy(w_busy), .done(w_done), .in_valid(w_in_valid), .in_data(w_in_data),
        .in_ready(w_in_ready), .out_valid(w_out_valid), .out_data(w_out_data),
        .out_last(w_out_last), .out_ready(w_out_ready)
    );

    // All helpers are entered and left on a falling edge.
    task automatic go(input logic [15:0] cfg);
        cfg_num_win = cfg;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input logic [15:0] d, output bit ok);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pop(output logic [15:0] d, output logic l, output bit ok);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid;
        d  = out_data;
        l  = out_last;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%0b want=0", out_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%04h want=0000", out_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] ev [4];
        bit ok;
        ev = '{16'h3F80, 16'h4000, 16'h3F00, 16'h3E00};
        go(16'd1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0b want=1", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%0b want=1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            push(ev[i], ok);
            total++; if (!ok) begin bad++; $display("FAIL basic_push_timeout got=0 want=1"); end
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%0b want=1", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_hold_in_ready got=%0b want=0", in_ready); end
        total++; if (out_data !== 16'h4000) begin bad++; $display("FAIL basic_out_data got=%04h want=4000", out_data); end
        total++; if (out_last !== 1'b1) begin bad++; $display("FAIL basic_out_last got=%0b want=1", out_last); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%0b want=1", done); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_at_done got=%0b want=1", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_after got=%0b want=0", out_valid); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%0b want=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_drop got=%0b want=0", busy); end
    endtask

    task automatic test_sign_tie();
        logic [15:0] ev [8];
        logic [15:0] d;
        logic l;
        bit ok;
        ev = '{16'hC100, 16'h0001, 16'h8000, 16'h0001,
               16'hC100, 16'hC200, 16'hC000, 16'hC180};
        go(16'd2);
        for (int i = 0; i < 4; i++) push(ev[i], ok);
        pop(d, l, ok);
        total++; if (!ok) begin bad++; $display("FAIL sign_pop0_timeout got=0 want=1"); end
        total++; if (d !== 16'h0001) begin bad++; $display("FAIL sign_win0 got=%04h want=0001", d); end
        total++; if (l !== 1'b0) begin bad++; $display("FAIL sign_last0 got=%0b want=0", l); end
        for (int i = 4; i < 8; i++) push(ev[i], ok);
        pop(d, l, ok);
        total++; if (!ok) begin bad++; $display("FAIL sign_pop1_timeout got=0 want=1"); end
        total++; if (d !== 16'hC200) begin bad++; $display("FAIL sign_win1 got=%04h want=c200", d); end
        total++; if (l !== 1'b1) begin bad++; $display("FAIL sign_last1 got=%0b want=1", l); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL sign_done got=%0b want=1", done); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [15:0] ev [12];
        logic [15:0] exp_max [3];
        logic [15:0] d;
        logic l;
        bit ok;
        ev = '{16'h0010, 16'h0200, 16'h0100, 16'h0005,
               16'h8005, 16'h8001, 16'h8003, 16'h8002,
               16'h7FFF, 16'h0000, 16'hFFFF, 16'h7FFE};
        exp_max = '{16'h0200, 16'h8005, 16'h7FFF};
        go(16'd3);
        for (int w = 0; w < 3; w++) begin
            for (int e = 0; e < 4; e++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                push(ev[w*4+e], ok);
                total++; if (!ok) begin bad++; $display("FAIL bp_push_timeout w=%0d e=%0d", w, e); end
            end
            // A junk element offered during HOLD must not be taken.
            in_valid = 1'b1;
            in_data  = 16'h7F00;
            for (int k = 0; k < 5; k++) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid w=%0d got=%0b want=1", w, out_valid); end
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_in_ready w=%0d got=%0b want=0", w, in_ready); end
                total++; if (out_data !== exp_max[w]) begin bad++; $display("FAIL bp_hold_data w=%0d got=%04h want=%04h", w, out_data, exp_max[w]); end
                total++; if (out_last !== (w == 2)) begin bad++; $display("FAIL bp_hold_last w=%0d got=%0b want=%0b", w, out_last, (w == 2)); end
                @(negedge clk);
            end
            in_valid = 1'b0;
            pop(d, l, ok);
            total++; if (!ok) begin bad++; $display("FAIL bp_pop_timeout w=%0d", w); end
            total++; if (d !== exp_max[w]) begin bad++; $display("FAIL bp_result w=%0d got=%04h want=%04h", w, d, exp_max[w]); end
            total++; if (l !== (w == 2)) begin bad++; $display("FAIL bp_last w=%0d got=%0b want=%0b", w, l, (w == 2)); end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL bp_done got=%0b want=1", done); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_extra_result got=%0b want=0", out_valid); end
        end
    endtask

    task automatic test_zero_windows();
        go(16'd0);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%0b want=1", done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL zero_in_ready got=%0b want=0", in_ready); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse got=%0b want=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_idle got=%0b want=0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_valid_late got=%0b want=0", out_valid); end
    endtask

    task automatic test_win_len_one();
        w_cfg = 16'd2;
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        total++; if (w_in_ready !== 1'b1) begin bad++; $display("FAIL w1_in_ready got=%0b want=1", w_in_ready); end
        w_in_valid = 1'b1;
        w_in_data  = 16'h1234;
        @(negedge clk);
        w_in_valid = 1'b0;
        total++; if (w_out_valid !== 1'b1) begin bad++; $display("FAIL w1_valid0 got=%0b want=1", w_out_valid); end
        total++; if (w_out_data !== 16'h1234) begin bad++; $display("FAIL w1_data0 got=%04h want=1234", w_out_data); end
        total++; if (w_out_last !== 1'b0) begin bad++; $display("FAIL w1_last0 got=%0b want=0", w_out_last); end
        w_out_ready = 1'b1;
        @(negedge clk);
        w_out_ready = 1'b0;
        total++; if (w_in_ready !== 1'b1) begin bad++; $display("FAIL w1_in_ready1 got=%0b want=1", w_in_ready); end
        w_in_valid = 1'b1;
        w_in_data  = 16'h8001;
        @(negedge clk);
        w_in_valid = 1'b0;
        total++; if (w_out_valid !== 1'b1) begin bad++; $display("FAIL w1_valid1 got=%0b want=1", w_out_valid); end
        total++; if (w_out_data !== 16'h8001) begin bad++; $display("FAIL w1_data1 got=%04h want=8001", w_out_data); end
        total++; if (w_out_last !== 1'b1) begin bad++; $display("FAIL w1_last1 got=%0b want=1", w_out_last); end
        w_out_ready = 1'b1;
        @(negedge clk);
        w_out_ready = 1'b0;
        total++; if (w_done !== 1'b1) begin bad++; $display("FAIL w1_done got=%0b want=1", w_done); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] ev [4];
        logic [15:0] d;
        logic l;
        bit ok;
        ev = '{16'h0001, 16'h0002, 16'h0003, 16'h0000};
        go(16'd1);
        push(16'h7000, ok);
        push(16'h7100, ok);
        rst = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_in_ready got=%0b want=0", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b want=0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0b want=0", out_valid); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%0b want=0", done); end
        total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL rstmid_data got=%04h want=0000", out_data); end
        rst = 1'b0;
        @(negedge clk);
        go(16'd1);
        for (int i = 0; i < 4; i++) push(ev[i], ok);
        pop(d, l, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_pop_timeout got=0 want=1"); end
        total++; if (d !== 16'h0003) begin bad++; $display("FAIL rstmid_result got=%04h want=0003", d); end
        total++; if (l !== 1'b1) begin bad++; $display("FAIL rstmid_last got=%0b want=1", l); end
        @(negedge clk);
    endtask

    task automatic test_ignored_start();
        logic [15:0] d;
        logic l;
        bit ok;
        go(16'd2);
        push(16'h0100, ok);
        cfg_num_win = 16'd5;
        start = 1'b1;
        push(16'h0300, ok);
        start = 1'b0;
        cfg_num_win = 16'd0;
        push(16'h0200, ok);
        push(16'h0050, ok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pop(d, l, ok);
        total++; if (d !== 16'h0300) begin bad++; $display("FAIL ign_win0 got=%04h want=0300", d); end
        total++; if (l !== 1'b0) begin bad++; $display("FAIL ign_last0 got=%0b want=0", l); end
        push(16'h0400, ok);
        push(16'h0401, ok);
        push(16'h0402, ok);
        push(16'h0403, ok);
        pop(d, l, ok);
        total++; if (!ok) begin bad++; $display("FAIL ign_pop_timeout got=0 want=1"); end
        total++; if (d !== 16'h0403) begin bad++; $display("FAIL ign_win1 got=%04h want=0403", d); end
        total++; if (l !== 1'b1) begin bad++; $display("FAIL ign_last1 got=%0b want=1", l); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_done got=%0b want=1", done); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy got=%0b want=0", busy); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ign_extra got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ign_in_ready got=%0b want=0", in_ready); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; cfg_num_win = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        w_start = 1'b0; w_cfg = '0; w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_sign_tie();
        test_backpressure();
        test_zero_windows();
        test_win_len_one();
        test_reset_mid_frame();
        test_ignored_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
